// File: rtl/seg_display_decoder.sv
// Seven-segment display snooper: watches a multiplexed segment/anode bus,
// debounces each slot, decodes the units and tens digits and publishes the pair.
module seg_display_decoder #(
  parameter              DISPLAY_TYPE   = "ANODE_COMMON",
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] seg,
  input  logic [7:0] an,
  output logic [3:0] unidades,
  output logic [3:0] decenas,
  output logic       valid,
  output logic       changed,
  output logic       code_err,
  output logic       stale
);

  localparam bit          INVERT_SEG = (DISPLAY_TYPE == "ANODE_COMMON");
  localparam int unsigned SW         = 15;
  localparam int unsigned CW         = 8;
  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    AN_UNITS   = 8'hFE;
  localparam logic [7:0]    AN_TENS    = 8'hFD;

  logic [SW-1:0] sample_q, sample_d;
  logic [SW-1:0] prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    pend_u_q, pend_u_d;
  logic [3:0]    pend_t_q, pend_t_d;
  logic          seen_u_q, seen_u_d;
  logic          seen_t_q, seen_t_d;
  logic [3:0]    unidades_q, unidades_d;
  logic [3:0]    decenas_q, decenas_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          code_err_q, code_err_d;
  logic          stale_q, stale_d;

  logic          fire_c;
  logic          slot_u_c;
  logic          slot_t_c;
  logic          good_c;
  logic [4:0]    dec_c;

  // Lit pattern (bit6 = g .. bit0 = a) to {ok, digit}
  function automatic logic [4:0] decode_lit(input logic [6:0] lit);
    logic [4:0] r;
    case (lit)
      7'b0111111: r = {1'b1, 4'd0};
      7'b0000110: r = {1'b1, 4'd1};
      7'b1011011: r = {1'b1, 4'd2};
      7'b1001111: r = {1'b1, 4'd3};
      7'b1100110: r = {1'b1, 4'd4};
      7'b1101101: r = {1'b1, 4'd5};
      7'b1111101: r = {1'b1, 4'd6};
      7'b0000111: r = {1'b1, 4'd7};
      7'b1111111: r = {1'b1, 4'd8};
      7'b1101111: r = {1'b1, 4'd9};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  // Sampling, debounce, slot capture, pair publish and staleness tracking
  always_comb begin
    sample_d   = sample_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    pend_u_d   = pend_u_q;
    pend_t_d   = pend_t_q;
    seen_u_d   = seen_u_q;
    seen_t_d   = seen_t_q;
    unidades_d = unidades_q;
    decenas_d  = decenas_q;
    valid_d    = 1'b0;
    changed_d  = 1'b0;
    code_err_d = 1'b0;
    stale_d    = stale_q;
    fire_c     = 1'b0;
    good_c     = 1'b0;
    slot_u_c   = (sample_q[14:7] == AN_UNITS);
    slot_t_c   = (sample_q[14:7] == AN_TENS);
    dec_c      = decode_lit(sample_q[6:0]);

    if (enable) begin
      sample_d = {an, (INVERT_SEG ? ~seg : seg)};
      prev_d   = sample_q;

      if (sample_q != prev_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != STABLE_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end

      // Capture only on the edge the counter first reaches the threshold
      fire_c     = (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);
      good_c     = fire_c && (slot_u_c || slot_t_c) && dec_c[4];
      code_err_d = fire_c && (slot_u_c || slot_t_c) && !dec_c[4];

      if (good_c) begin
        tmo_d = '0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + TW'(1);
      end
      stale_d = (tmo_d == TMO_MAX);

      if (seen_u_q && seen_t_q) begin
        unidades_d = pend_u_q;
        decenas_d  = pend_t_q;
        valid_d    = 1'b1;
        changed_d  = ({pend_t_q, pend_u_q} != {decenas_q, unidades_q});
        seen_u_d   = 1'b0;
        seen_t_d   = 1'b0;
      end

      // A capture landing on a publish edge starts the next pair
      if (good_c && slot_u_c) begin
        pend_u_d = dec_c[3:0];
        seen_u_d = 1'b1;
      end
      if (good_c && slot_t_c) begin
        pend_t_d = dec_c[3:0];
        seen_t_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      pend_u_q   <= '0;
      pend_t_q   <= '0;
      seen_u_q   <= 1'b0;
      seen_t_q   <= 1'b0;
      unidades_q <= '0;
      decenas_q  <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      code_err_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      pend_u_q   <= pend_u_d;
      pend_t_q   <= pend_t_d;
      seen_u_q   <= seen_u_d;
      seen_t_q   <= seen_t_d;
      unidades_q <= unidades_d;
      decenas_q  <= decenas_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      code_err_q <= code_err_d;
      stale_q    <= stale_d;
    end
  end

  assign unidades = unidades_q;
  assign decenas  = decenas_q;
  assign valid    = valid_q;
  assign changed  = changed_q;
  assign code_err = code_err_q;
  assign stale    = stale_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder with a publish scoreboard.
module tb_seg_display_decoder;

  localparam logic [6:0] L1 = 7'b0000110;
  localparam logic [6:0] L2 = 7'b1011011;
  localparam logic [6:0] L3 = 7'b1001111;
  localparam logic [6:0] L4 = 7'b1100110;
  localparam logic [6:0] L5 = 7'b1101101;
  localparam logic [6:0] L6 = 7'b1111101;
  localparam logic [6:0] L7 = 7'b0000111;
  localparam logic [6:0] L8 = 7'b1111111;
  localparam logic [6:0] L9 = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [7:0] an = 8'hFF;
  logic [3:0] unidades, decenas;
  logic       valid, changed, code_err, stale;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_cerr = 0;
  int base_v, base_e, vt;
  logic [8:0] sb[$];
  logic [8:0] exp_pub;

  seg_display_decoder #(
    .DISPLAY_TYPE("ANODE_COMMON"),
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .seg(seg),
    .an(an),
    .unidades(unidades),
    .decenas(decenas),
    .valid(valid),
    .changed(changed),
    .code_err(code_err),
    .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock edge, then compare any publish against the scoreboard
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_pub = sb.pop_front();
        check("publish {dec,uni,chg}", 32'({decenas, unidades, changed}), 32'(exp_pub));
      end
    end else if (changed === 1'b1) begin
      check("changed_without_valid", 32'(valid), 32'd1);
    end
    if (code_err === 1'b1) n_cerr++;
  endtask

  // Present a digit slot in common-anode polarity (lit = low)
  task automatic drive(input logic [7:0] a, input logic [6:0] lit, input int n);
    an  = a;
    seg = ~lit;
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    check("reset_unidades", 32'(unidades), 32'd0);
    check("reset_decenas", 32'(decenas), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_stale", 32'(stale), 32'd0);

    // Units 2 then tens 3, publish latency STABLE+2
    base_v = n_valid;
    drive(8'hFE, L2, 10);
    sb.push_back({4'd3, 4'd2, 1'b1});
    an = 8'hFD; seg = ~L3; vt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (valid === 1'b1) vt = i;
    end
    check("latency_edges", 32'(vt), 32'd6);
    check("pair23_valid_count", 32'(n_valid - base_v), 32'd1);
    check("pair23_unidades", 32'(unidades), 32'd2);
    check("pair23_decenas", 32'(decenas), 32'd3);

    // Short-lived patterns never capture
    base_v = n_valid; base_e = n_cerr;
    drive(8'hFE, L5, 3);
    drive(8'hFE, L1, 3);
    drive(8'hFF, L7, 8);
    check("short_no_valid", 32'(n_valid - base_v), 32'd0);
    check("short_no_err", 32'(n_cerr - base_e), 32'd0);

    // Blank units slot is undecodable
    base_e = n_cerr;
    drive(8'hFE, 7'b0, 6);
    check("blank_one_code_err", 32'(n_cerr - base_e), 32'd1);
    check("blank_unidades_kept", 32'(unidades), 32'd2);
    check("blank_decenas_kept", 32'(decenas), 32'd3);

    // Repeat of 23: valid without changed
    base_v = n_valid;
    drive(8'hFE, L2, 10);
    sb.push_back({4'd3, 4'd2, 1'b0});
    drive(8'hFD, L3, 10);
    check("repeat23_valid_count", 32'(n_valid - base_v), 32'd1);

    // A new pair 79
    sb.push_back({4'd7, 4'd9, 1'b1});
    drive(8'hFE, L9, 10);
    drive(8'hFD, L7, 10);
    check("pair79_unidades", 32'(unidades), 32'd9);
    check("pair79_decenas", 32'(decenas), 32'd7);

    // Staleness counts only enabled cycles
    reset = 1'b1; an = 8'hFF; seg = 7'h7F;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    enable = 1'b0;
    repeat (5) tick();
    check("stale_frozen_while_disabled", 32'(stale), 32'd0);
    enable = 1'b1;
    repeat (5) tick();
    check("stale_after_15", 32'(stale), 32'd0);
    tick();
    check("stale_after_16", 32'(stale), 32'd1);

    // Stale clears at the units capture; publish is held while disabled
    sb.push_back({4'd8, 4'd4, 1'b1});
    drive(8'hFE, L4, 4);
    check("stale_before_capture", 32'(stale), 32'd1);
    tick();
    check("stale_after_capture", 32'(stale), 32'd0);
    drive(8'hFE, L4, 5);
    base_v = n_valid;
    drive(8'hFD, L8, 5);
    enable = 1'b0;
    repeat (3) tick();
    check("no_valid_while_disabled", 32'(n_valid - base_v), 32'd0);
    enable = 1'b1;
    tick();
    check("valid_after_reenable", 32'(n_valid - base_v), 32'd1);
    check("pair84_unidades", 32'(unidades), 32'd4);

    // Reset between units and tens drops the partial pair
    drive(8'hFE, L6, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_unidades", 32'(unidades), 32'd0);
    check("midreset_decenas", 32'(decenas), 32'd0);
    check("midreset_flags", 32'({valid, changed, code_err, stale}), 32'd0);
    base_v = n_valid;
    drive(8'hFD, L1, 10);
    check("midreset_tens_alone", 32'(n_valid - base_v), 32'd0);
    sb.push_back({4'd1, 4'd6, 1'b1});
    drive(8'hFE, L6, 10);
    check("midreset_then_both", 32'(n_valid - base_v), 32'd1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("total_code_err", 32'(n_cerr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
